// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key sequencer: scan codes, calculator key codes,
// prefix FSM state encoding and the decode result type.
package ps2_pkg;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_0     = 8'h70;
   localparam logic [7:0] SC_1     = 8'h69;
   localparam logic [7:0] SC_2     = 8'h72;
   localparam logic [7:0] SC_3     = 8'h7A;
   localparam logic [7:0] SC_4     = 8'h6B;
   localparam logic [7:0] SC_5     = 8'h73;
   localparam logic [7:0] SC_6     = 8'h74;
   localparam logic [7:0] SC_7     = 8'h6C;
   localparam logic [7:0] SC_8     = 8'h75;
   localparam logic [7:0] SC_9     = 8'h7D;
   localparam logic [7:0] SC_ADD   = 8'h79;
   localparam logic [7:0] SC_SUB   = 8'h7B;
   localparam logic [7:0] SC_MUL   = 8'h7C;
   localparam logic [7:0] SC_DIV   = 8'h4A;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   localparam logic [4:0] KEY_0     = 5'd0;
   localparam logic [4:0] KEY_1     = 5'd1;
   localparam logic [4:0] KEY_2     = 5'd2;
   localparam logic [4:0] KEY_3     = 5'd3;
   localparam logic [4:0] KEY_4     = 5'd4;
   localparam logic [4:0] KEY_5     = 5'd5;
   localparam logic [4:0] KEY_6     = 5'd6;
   localparam logic [4:0] KEY_7     = 5'd7;
   localparam logic [4:0] KEY_8     = 5'd8;
   localparam logic [4:0] KEY_9     = 5'd9;
   localparam logic [4:0] KEY_ADD   = 5'd10;
   localparam logic [4:0] KEY_SUB   = 5'd11;
   localparam logic [4:0] KEY_MUL   = 5'd12;
   localparam logic [4:0] KEY_DIV   = 5'd13;
   localparam logic [4:0] KEY_ENTER = 5'd14;
   localparam logic [4:0] KEY_BKSP  = 5'd15;
   localparam logic [4:0] KEY_CLR   = 5'd16;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_E0   = 2'd1;
   localparam logic [1:0] S_F0   = 2'd2;
   localparam logic [1:0] S_E0F0 = 2'd3;

   typedef struct packed {
      logic       hit;
      logic [4:0] code;
   } key_dec_t;

endpackage

// File: rtl/ps2_key_fifo.sv
// Small first-word-fall-through FIFO for decoded keys; reports an overflow
// pulse when a push is refused because the FIFO is full and nothing pops.
module ps2_key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push  = push && (!full || do_pop);
   assign overflow = push && full && !do_pop;
   assign dout     = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns the raw PS/2 scan-code byte stream into calculator key codes, tracking
// E0/F0 prefixes, filtering breaks and typematic repeats, and buffering keys.
module ps2_key_sequencer
   import ps2_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 50000,
   parameter int REPEAT_EN   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [4:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic       prefix_busy
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   function automatic key_dec_t decode_scan(input logic [7:0] sc, input logic ext);
      key_dec_t d;
      d.hit  = 1'b1;
      d.code = KEY_0;
      if (ext) begin
         case (sc)
            SC_DIV:   d.code = KEY_DIV;
            SC_ENTER: d.code = KEY_ENTER;
            default:  d.hit  = 1'b0;
         endcase
      end else begin
         case (sc)
            SC_0:     d.code = KEY_0;
            SC_1:     d.code = KEY_1;
            SC_2:     d.code = KEY_2;
            SC_3:     d.code = KEY_3;
            SC_4:     d.code = KEY_4;
            SC_5:     d.code = KEY_5;
            SC_6:     d.code = KEY_6;
            SC_7:     d.code = KEY_7;
            SC_8:     d.code = KEY_8;
            SC_9:     d.code = KEY_9;
            SC_ADD:   d.code = KEY_ADD;
            SC_SUB:   d.code = KEY_SUB;
            SC_MUL:   d.code = KEY_MUL;
            SC_ENTER: d.code = KEY_ENTER;
            SC_BKSP:  d.code = KEY_BKSP;
            SC_ESC:   d.code = KEY_CLR;
            default:  d.hit  = 1'b0;
         endcase
      end
      return d;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          held_valid_q, held_valid_d;
   logic [8:0]    held_key_q, held_key_d;
   logic          ovf_q, ovf_d;

   logic       make_ev;
   logic       break_ev;
   logic       ev_ext;
   logic [8:0] ev_key;
   logic       repeat_hit;
   key_dec_t   dec;
   logic       push;
   logic       pop;
   logic       fifo_empty;
   logic       fifo_ovf;
   logic       unused_full;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      make_ev  = 1'b0;
      break_ev = 1'b0;
      ev_ext   = 1'b0;
      if (rx_valid) begin
         timer_d = '0;
         case (state_q)
            S_IDLE: begin
               if (rx_data == SC_E0)      state_d = S_E0;
               else if (rx_data == SC_F0) state_d = S_F0;
               else                       make_ev = 1'b1;
            end
            S_E0: begin
               if (rx_data == SC_F0) begin
                  state_d = S_E0F0;
               end else if (rx_data != SC_E0) begin
                  make_ev = 1'b1;
                  ev_ext  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_F0: begin
               // A second prefix after F0 is malformed; abandon silently.
               state_d  = S_IDLE;
               break_ev = (rx_data != SC_E0) && (rx_data != SC_F0);
            end
            default: begin
               break_ev = 1'b1;
               ev_ext   = 1'b1;
               state_d  = S_IDLE;
            end
         endcase
      end else if (state_q != S_IDLE) begin
         if (timer_q == TO_LAST) begin
            state_d = S_IDLE;
            timer_d = '0;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   // The held key is the physical key (extension bit plus scan code), so
   // keypad Enter and main Enter are tracked as different keys.
   assign ev_key     = {ev_ext, rx_data};
   assign dec        = decode_scan(rx_data, ev_ext);
   assign repeat_hit = held_valid_q && (held_key_q == ev_key);

   always_comb begin
      held_valid_d = held_valid_q;
      held_key_d   = held_key_q;
      push         = 1'b0;
      if (make_ev && dec.hit) begin
         if ((REPEAT_EN != 0) || !repeat_hit) begin
            push         = 1'b1;
            held_valid_d = 1'b1;
            held_key_d   = ev_key;
         end
      end else if (break_ev && dec.hit && repeat_hit) begin
         held_valid_d = 1'b0;
      end
   end

   assign pop   = key_valid && key_ready;
   assign ovf_d = fifo_ovf ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

   ps2_key_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (5)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .din      (dec.code),
      .pop      (pop),
      .dout     (key_code),
      .full     (unused_full),
      .empty    (fifo_empty),
      .overflow (fifo_ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         held_valid_q <= 1'b0;
         held_key_q   <= '0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         held_valid_q <= held_valid_d;
         held_key_q   <= held_key_d;
         ovf_q        <= ovf_d;
      end
   end

   assign key_valid   = !fifo_empty;
   assign ovf         = ovf_q;
   assign prefix_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench: two sequencers (repeat filtering on and off) share one
// randomized byte stream and are checked against a behavioural key model.
module tb_ps2_key_sequencer;

   localparam int DEPTH = 4;
   localparam int TO    = 16;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic [7:0] rx_data   = 8'h00;
   logic       rx_valid  = 1'b0;
   logic       key_ready = 1'b0;
   logic       ovf_clr   = 1'b0;

   logic [4:0] key_code    [2];
   logic       key_valid   [2];
   logic       ovf         [2];
   logic       prefix_busy [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      ps2_key_sequencer #(
         .DEPTH       (DEPTH),
         .TIMEOUT_CYC (TO),
         .REPEAT_EN   (gi)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .rx_data     (rx_data),
         .rx_valid    (rx_valid),
         .key_code    (key_code[gi]),
         .key_valid   (key_valid[gi]),
         .key_ready   (key_ready),
         .ovf         (ovf[gi]),
         .ovf_clr     (ovf_clr),
         .prefix_busy (prefix_busy[gi])
      );
   end

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // Reference model: physical key {ext, scan} -> calculator code
   int      dec_map [bit [8:0]];
   bit      pe0 = 1'b0, pf0 = 1'b0;
   int      cyc = 0, last_rx = 0;
   bit      held_v [2];
   bit [8:0] held_k [2];
   int      occ [2];
   bit      ovf_m [2];
   bit      pop_m [2];
   bit      push_m [2];
   bit      ovf_set [2];
   int      sb0 [$];
   int      sb1 [$];

   bit [7:0] pool [12] = '{8'h69, 8'h70, 8'h5A, 8'h4A, 8'hE0, 8'hF0,
                           8'hF0, 8'hE0, 8'h66, 8'h7C, 8'h1C, 8'h7B};

   task automatic chk(input string name, input int r, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s dut%0d: got %0d, expected %0d at t=%0t", name, r, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pe0 = 1'b0;
      pf0 = 1'b0;
      last_rx = cyc;
      for (int r = 0; r < 2; r++) begin
         held_v[r] = 1'b0;
         held_k[r] = '0;
         occ[r]    = 0;
         ovf_m[r]  = 1'b0;
      end
      sb0.delete();
      sb1.delete();
   endtask

   task automatic key_make(input bit [8:0] k);
      if (!dec_map.exists(k)) return;
      for (int r = 0; r < 2; r++) begin
         if (r == 0 && held_v[r] && held_k[r] == k) continue;
         held_v[r] = 1'b1;
         held_k[r] = k;
         if (occ[r] < DEPTH || pop_m[r]) begin
            push_m[r] = 1'b1;
            if (r == 0) sb0.push_back(dec_map[k]);
            else        sb1.push_back(dec_map[k]);
         end else begin
            ovf_set[r] = 1'b1;
         end
      end
   endtask

   task automatic key_break(input bit [8:0] k);
      if (!dec_map.exists(k)) return;
      for (int r = 0; r < 2; r++) begin
         if (held_v[r] && held_k[r] == k) held_v[r] = 1'b0;
      end
   endtask

   task automatic take_byte(input bit [7:0] b);
      if (!pe0 && !pf0) begin
         if (b == 8'hE0)      pe0 = 1'b1;
         else if (b == 8'hF0) pf0 = 1'b1;
         else                 key_make({1'b0, b});
      end else if (pe0 && !pf0) begin
         if (b == 8'hF0) begin
            pf0 = 1'b1;
         end else if (b != 8'hE0) begin
            key_make({1'b1, b});
            pe0 = 1'b0;
         end
      end else if (!pe0 && pf0) begin
         if (b != 8'hE0 && b != 8'hF0) key_break({1'b0, b});
         pf0 = 1'b0;
      end else begin
         key_break({1'b1, b});
         pe0 = 1'b0;
         pf0 = 1'b0;
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_reset();
      end else begin
         cyc++;
         for (int r = 0; r < 2; r++) begin
            pop_m[r]   = key_ready && occ[r] > 0;
            push_m[r]  = 1'b0;
            ovf_set[r] = 1'b0;
         end
         if (rx_valid) begin
            last_rx = cyc;
            take_byte(rx_data);
         end else if ((pe0 || pf0) && (cyc - last_rx >= TO)) begin
            pe0 = 1'b0;
            pf0 = 1'b0;
         end
         for (int r = 0; r < 2; r++) begin
            occ[r] = occ[r] + int'(push_m[r]) - int'(pop_m[r]);
            if (ovf_set[r])   ovf_m[r] = 1'b1;
            else if (ovf_clr) ovf_m[r] = 1'b0;
         end
      end
   end

   // Monitor: compare the DUT against the scoreboard between clock edges
   always @(negedge clk) begin
      for (int r = 0; r < 2; r++) begin
         bit exp_v;
         int head;
         exp_v = (r == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
         chk("key_valid", r, 32'(key_valid[r]), 32'(exp_v));
         if (key_valid[r] && exp_v) begin
            head = (r == 0) ? sb0[0] : sb1[0];
            chk("key_code", r, 32'(key_code[r]), head);
            if (key_ready) begin
               if (r == 0) void'(sb0.pop_front());
               else        void'(sb1.pop_front());
            end
         end
         chk("ovf", r, 32'(ovf[r]), 32'(ovf_m[r]));
         chk("prefix_busy", r, 32'(prefix_busy[r]), 32'(pe0 || pf0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input bit [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_list(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2,
                            input bit [7:0] b3, input bit [7:0] b4, input int n);
      bit [7:0] lst [5];
      lst = '{b0, b1, b2, b3, b4};
      for (int i = 0; i < n; i++) send(lst[i]);
   endtask

   initial begin
      dec_map[9'h070] = 0;  dec_map[9'h069] = 1;  dec_map[9'h072] = 2;
      dec_map[9'h07A] = 3;  dec_map[9'h06B] = 4;  dec_map[9'h073] = 5;
      dec_map[9'h074] = 6;  dec_map[9'h06C] = 7;  dec_map[9'h075] = 8;
      dec_map[9'h07D] = 9;  dec_map[9'h079] = 10; dec_map[9'h07B] = 11;
      dec_map[9'h07C] = 12; dec_map[9'h14A] = 13; dec_map[9'h15A] = 14;
      dec_map[9'h05A] = 14; dec_map[9'h066] = 15; dec_map[9'h076] = 16;

      repeat (3) tick();
      for (int r = 0; r < 2; r++) begin
         chk("rst_key_valid", r, 32'(key_valid[r]), 0);
         chk("rst_key_code", r, 32'(key_code[r]), 0);
         chk("rst_ovf", r, 32'(ovf[r]), 0);
         chk("rst_prefix_busy", r, 32'(prefix_busy[r]), 0);
      end
      rst = 1'b1;
      tick();

      key_ready = 1'b1;
      send(8'h69);                                   idle(3);
      send_list(8'hF0, 8'h69, 8'h00, 8'h00, 8'h00, 2); idle(2);
      send(8'h69);                                   idle(2);
      send_list(8'hF0, 8'h69, 8'h00, 8'h00, 8'h00, 2); idle(2);
      send_list(8'h69, 8'h69, 8'h69, 8'hF0, 8'h69, 5); send(8'h69); idle(3);
      send_list(8'hE0, 8'h4A, 8'hE0, 8'h5A, 8'h5A, 5);
      send_list(8'hF0, 8'h5A, 8'hE0, 8'h70, 8'h00, 4); idle(3);

      // Dangling E0 must be abandoned after the idle timeout
      send(8'hE0);
      idle(TO - 2);
      for (int r = 0; r < 2; r++) chk("busy_before_timeout", r, 32'(prefix_busy[r]), 1);
      idle(4);
      for (int r = 0; r < 2; r++) chk("busy_after_timeout", r, 32'(prefix_busy[r]), 0);
      send(8'h70); idle(3);

      // Fill past capacity with the consumer stalled
      send_list(8'hF0, 8'h70, 8'h00, 8'h00, 8'h00, 2);
      key_ready = 1'b0;
      send_list(8'h70, 8'h69, 8'h72, 8'h7A, 8'h7D, 5);
      for (int r = 0; r < 2; r++) chk("ovf_after_fill", r, 32'(ovf[r]), 1);
      key_ready = 1'b1;
      idle(6);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      for (int r = 0; r < 2; r++) chk("ovf_after_clr", r, 32'(ovf[r]), 0);

      // Overflow and clear in the same cycle: the overflow wins
      key_ready = 1'b0;
      send_list(8'h6B, 8'h73, 8'h74, 8'h6C, 8'h00, 4);
      ovf_clr = 1'b1;
      send(8'h75);
      ovf_clr = 1'b0;
      for (int r = 0; r < 2; r++) chk("ovf_beats_clr", r, 32'(ovf[r]), 1);
      key_ready = 1'b1;
      idle(6);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

      // Reset in the middle of a prefix with keys buffered
      key_ready = 1'b0;
      send(8'h66);
      send(8'hE0);
      rst = 1'b0;
      #1;
      for (int r = 0; r < 2; r++) begin
         chk("midrst_key_valid", r, 32'(key_valid[r]), 0);
         chk("midrst_prefix_busy", r, 32'(prefix_busy[r]), 0);
      end
      tick(); tick();
      rst = 1'b1;
      tick();

      for (int i = 0; i < 1500; i++) begin
         key_ready = ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 99) < 3) begin
            ovf_clr = 1'b0;
            idle($urandom_range(TO - 2, TO + 3));
         end else begin
            rx_data  = pool[$urandom_range(0, 11)];
            rx_valid = ($urandom_range(0, 2) != 0);
            tick();
         end
      end
      rx_valid  = 1'b0;
      ovf_clr   = 1'b0;
      key_ready = 1'b1;
      idle(10);
      chk("drain_empty", 0, sb0.size(), 0);
      chk("drain_empty", 1, sb1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
Controller that sits between the PS/2 frame receiver and the calculator core. It consumes the receiver's raw scan-code byte stream and tracks the E0 (extended) and F0 (break) prefixes. Make codes are decoded into 5-bit calculator key codes, and break codes and typematic repeats are filtered out. Decoded keys are buffered in a small FIFO and handed to the core over a valid/ready handshake.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
TIMEOUT_CYC, 50000, idle clk cycles after a prefix byte before the prefix is abandoned.
REPEAT_EN, 0, 1 = pass typematic repeats; 0 = suppress a make of the currently held key.

Ports:
clk  in  1  system clock, all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
rx_data  in  8  scan-code byte from the frame receiver.
rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
key_code  out  5  decoded key at the FIFO head.
key_valid  out  1  FIFO not empty.
key_ready  in  1  core accepts key_code; pop occurs when key_valid && key_ready.
ovf  out  1  sticky flag: a key was dropped because the FIFO was full.
ovf_clr  in  1  clears ovf. If ovf_clr and a new overflow occur in the same cycle, the overflow wins.
prefix_busy  out  1  prefix FSM is not in S_IDLE (debug).

Behaviour:
- Reset (rst=0, asynchronous): FSM returns to S_IDLE, the FIFO empties, held_valid=0 and the timeout counter clears. Outputs: key_valid=0, key_code=0, ovf=0, prefix_busy=0. A reset mid-prefix or with the FIFO partly full discards everything.
- Prefix FSM states: S_IDLE, S_E0, S_F0, S_E0F0.
  - From S_IDLE: E0 goes to S_E0; F0 goes to S_F0; any other byte is a make (ext=0).
  - From S_E0: F0 goes to S_E0F0; E0 stays in S_E0; any other byte is a make (ext=1), then S_IDLE.
  - From S_F0: any byte other than E0 or F0 is a break (ext=0), then S_IDLE. E0 or F0 here is a protocol error and returns to S_IDLE with no event.
  - From S_E0F0: any byte is a break (ext=1), then S_IDLE.
- Timeout: the counter resets on every rx_valid. In any non-idle state, once the counter reaches TIMEOUT_CYC-1 the FSM returns to S_IDLE and no event is generated.
- Decode, non-extended:
  - Digits: 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9.
  - Operators: 79 '+'→10, 7B '-'→11, 7C '*'→12.
  - Control: 5A Enter→14, 66 Backspace→15, 76 Esc→16.
- Decode, extended: E0 4A '/'→13, E0 5A Enter→14.
- All other codes are unknown and silently dropped, with no state change.
- Make handling:
  - If REPEAT_EN=0 and held_valid && held_code==code, the make is dropped.
  - Otherwise the key is pushed, held_code is set to code and held_valid is set to 1.
- Break handling: a break of held_code clears held_valid. A break of any other key has no effect.
- Latency: rx_valid in cycle N with a decodable make pushes at the end of cycle N. key_valid is high from cycle N+1 when the FIFO was empty.
- FIFO: first-word-fall-through, with key_code driven by registered storage. Pointers are log2(DEPTH) bits and wrap; the count is log2(DEPTH)+1 bits.
  - Push while full with no pop in the same cycle: the key is dropped and ovf is set.
  - Push and pop in the same cycle while full: both are accepted and the count is unchanged.
  - Push and pop in the same cycle while empty: not possible, because key_valid=0.
- key_code holds its value while key_valid && !key_ready.

Decomposition:
- Shared package ps2_pkg:
  - Scan-code constants: SC_E0, SC_F0 and the per-key codes.
  - Key-code constants: KEY_0..KEY_9, KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_ENTER, KEY_BKSP, KEY_CLR.
  - FSM state encoding.
- One sub-module, ps2_key_fifo: a parameterized synchronous FWFT FIFO providing push, pop, full, empty and overflow.
- Decode is a combinational function within ps2_key_sequencer.

Test Plan:
- Send 69, key_ready=1 → key_valid high for one cycle at N+1 with key_code=1. ovf stays 0.
- Send F0,69 after a prior 69 has been popped → no key_valid pulse, held_valid=0. A following 69 → key_code=1.
- REPEAT_EN=0, send 69,69,69 then F0,69 then 69 → exactly two keys, both code 1. Repeat with REPEAT_EN=1 → four keys.
- Send E0,4A then E0,5A then 5A then F0,5A → keys 13, 14, 14. Send E0,70 (Insert) → nothing.
- Send E0, idle for TIMEOUT_CYC+2 cycles, then 70 → key_code=0, confirming the prefix was dropped. prefix_busy=0 after the timeout.
- key_ready=0, send 70,69,72,7A,7D → 4 keys buffered and ovf=1. Drain with key_ready=1 → 0,1,2,3. Pulse ovf_clr → ovf=0. Assert rst mid-stream after E0 → key_valid=0 and prefix_busy=0 immediately.
